// File: rtl/mmio_byte_bridge.sv
// mmio_byte_bridge: host-side debug master for the FPro MMIO bus.
// Decodes a byte-stream command protocol into single MMIO transactions and
// returns acknowledgements or read data as a byte stream.
//   Write frame: 'W' A2 A1 A0 D3 D2 D1 D0  -> response 'K'
//   Read  frame: 'R' A2 A1 A0              -> response D3 D2 D1 D0
//   Other opcode                           -> response '?'
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   rx_data/rx_valid  incoming command bytes (strobe, no backpressure)
//   tx_data/tx_valid/tx_ready  outgoing response bytes (valid/ready)
//   mmio_*            MMIO initiator signals (registered)
//   busy              high whenever the bridge is not idle
module mmio_byte_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy
);

    localparam int unsigned BW = 8;
    localparam int unsigned AW = 21;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] OP_WRITE = 8'h57;
    localparam logic [BW-1:0] OP_READ  = 8'h52;
    localparam logic [BW-1:0] RSP_OK   = 8'h4B;
    localparam logic [BW-1:0] RSP_BAD  = 8'h3F;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t         r_state;
    logic           r_is_wr;
    logic [1:0]     r_cnt;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_resp;
    logic [2:0]     r_resp_cnt;
    logic [TW-1:0]  r_timer;
    logic [BW-1:0]  r_tx_data;
    logic           r_tx_valid;
    logic           r_mmio_cs;
    logic           r_mmio_wr;
    logic           r_mmio_rd;
    logic [AW-1:0]  r_mmio_addr;
    logic [DW-1:0]  r_mmio_wr_data;
    logic           r_busy;

    state_t         w_state_nxt;
    logic           w_is_wr_nxt;
    logic [1:0]     w_cnt_nxt;
    logic [AW-1:0]  w_addr_nxt;
    logic [DW-1:0]  w_wdata_nxt;
    logic [DW-1:0]  w_resp_nxt;
    logic [2:0]     w_resp_cnt_nxt;
    logic [TW-1:0]  w_timer_nxt;
    logic [BW-1:0]  w_tx_data_nxt;
    logic           w_tx_valid_nxt;
    logic           w_mmio_cs_nxt;
    logic           w_mmio_wr_nxt;
    logic           w_mmio_rd_nxt;
    logic [AW-1:0]  w_mmio_addr_nxt;
    logic [DW-1:0]  w_mmio_wr_data_nxt;
    logic           w_busy_nxt;

    // Next-state and next-output logic; outputs are derived from the next
    // state so the strobes and tx_valid line up with the state they belong to.
    always_comb begin
        w_state_nxt        = r_state;
        w_is_wr_nxt        = r_is_wr;
        w_cnt_nxt          = r_cnt;
        w_addr_nxt         = r_addr;
        w_wdata_nxt        = r_wdata;
        w_resp_nxt         = r_resp;
        w_resp_cnt_nxt     = r_resp_cnt;
        w_timer_nxt        = '0;
        w_tx_data_nxt      = r_tx_data;
        w_tx_valid_nxt     = 1'b0;
        w_mmio_cs_nxt      = 1'b0;
        w_mmio_wr_nxt      = 1'b0;
        w_mmio_rd_nxt      = 1'b0;
        w_mmio_addr_nxt    = r_mmio_addr;
        w_mmio_wr_data_nxt = r_mmio_wr_data;
        w_busy_nxt         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        w_is_wr_nxt = (rx_data == OP_WRITE);
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_resp_nxt     = {RSP_BAD, 24'h000000};
                        w_resp_cnt_nxt = 3'd1;
                        w_state_nxt    = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                if (rx_valid) begin
                    // 21-bit shift register silently drops address bits 23:21
                    w_addr_nxt = {r_addr[AW-BW-1:0], rx_data};
                    if (r_cnt == 2'd2) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = r_is_wr ? S_DATA : S_BUS;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end else if (r_timer == T_LAST) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    w_wdata_nxt = {r_wdata[DW-BW-1:0], rx_data};
                    if (r_cnt == 2'd3) begin
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = S_BUS;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end else if (r_timer == T_LAST) begin
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            S_BUS: begin
                // Read data is valid during the strobe cycle only
                w_resp_nxt     = r_is_wr ? {RSP_OK, 24'h000000} : mmio_rd_data;
                w_resp_cnt_nxt = r_is_wr ? 3'd1 : 3'd4;
                w_state_nxt    = S_RESP;
            end

            S_RESP: begin
                if (r_tx_valid && tx_ready) begin
                    if (r_resp_cnt == 3'd1) begin
                        w_resp_cnt_nxt = 3'd0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_resp_nxt     = {r_resp[DW-BW-1:0], 8'h00};
                        w_resp_cnt_nxt = r_resp_cnt - 3'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);

        if (w_state_nxt == S_BUS) begin
            w_mmio_cs_nxt      = 1'b1;
            w_mmio_wr_nxt      = w_is_wr_nxt;
            w_mmio_rd_nxt      = !w_is_wr_nxt;
            w_mmio_addr_nxt    = w_addr_nxt;
            w_mmio_wr_data_nxt = w_wdata_nxt;
        end

        if (w_state_nxt == S_RESP) begin
            w_tx_valid_nxt = 1'b1;
            w_tx_data_nxt  = w_resp_nxt[DW-1:DW-BW];
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_is_wr        <= 1'b0;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_resp         <= '0;
            r_resp_cnt     <= '0;
            r_timer        <= '0;
            r_tx_data      <= '0;
            r_tx_valid     <= 1'b0;
            r_mmio_cs      <= 1'b0;
            r_mmio_wr      <= 1'b0;
            r_mmio_rd      <= 1'b0;
            r_mmio_addr    <= '0;
            r_mmio_wr_data <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_is_wr        <= w_is_wr_nxt;
            r_cnt          <= w_cnt_nxt;
            r_addr         <= w_addr_nxt;
            r_wdata        <= w_wdata_nxt;
            r_resp         <= w_resp_nxt;
            r_resp_cnt     <= w_resp_cnt_nxt;
            r_timer        <= w_timer_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_tx_valid     <= w_tx_valid_nxt;
            r_mmio_cs      <= w_mmio_cs_nxt;
            r_mmio_wr      <= w_mmio_wr_nxt;
            r_mmio_rd      <= w_mmio_rd_nxt;
            r_mmio_addr    <= w_mmio_addr_nxt;
            r_mmio_wr_data <= w_mmio_wr_data_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign mmio_cs      = r_mmio_cs;
    assign mmio_wr      = r_mmio_wr;
    assign mmio_rd      = r_mmio_rd;
    assign mmio_addr    = r_mmio_addr;
    assign mmio_wr_data = r_mmio_wr_data;
    assign busy         = r_busy;

endmodule

// File: tb/tb_mmio_byte_bridge.sv
// Directed bench for mmio_byte_bridge (TIMEOUT_CYCLES = 16).
module tb_mmio_byte_bridge;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;

    logic [31:0] rd_val = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    int         strobe_cnt = 0;
    int         both_err   = 0;
    logic [7:0] txq[$];

    mmio_byte_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .mmio_cs      (mmio_cs),
        .mmio_wr      (mmio_wr),
        .mmio_rd      (mmio_rd),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (mmio_rd_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Responder: read data only in the strobe cycle
    assign mmio_rd_data = (mmio_cs && mmio_rd) ? rd_val : 32'h0;

    // Monitor: count strobes and record accepted tx bytes
    always @(negedge clk) begin
        if (mmio_cs) begin
            strobe_cnt = strobe_cnt + 1;
            if (mmio_wr && mmio_rd) both_err = both_err + 1;
        end
        if (tx_valid && tx_ready && !reset) txq.push_back(tx_data);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if ({tx_valid, tx_data, mmio_cs, mmio_wr, mmio_rd, busy} !== 12'h000 || mmio_addr !== 21'h0 || mmio_wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: tx_valid=%b tx_data=%h cs=%b wr=%b rd=%b busy=%b addr=%h wdata=%h, want all 0", tx_valid, tx_data, mmio_cs, mmio_wr, mmio_rd, busy, mmio_addr, mmio_wr_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write;
        int sc0, q0;
        sc0 = strobe_cnt;
        q0  = txq.size();
        tx_ready = 1'b1;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        @(negedge clk);
        n_tests++;
        if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b110) begin n_fail++; $display("FAIL write_strobe: cs/wr/rd=%b want 110", {mmio_cs, mmio_wr, mmio_rd}); end
        n_tests++;
        if (mmio_addr !== 21'h000010 || mmio_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_addr_data: addr=%h data=%h want 000010 deadbeef", mmio_addr, mmio_wr_data); end
        @(negedge clk);
        n_tests++;
        if (mmio_cs !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin n_fail++; $display("FAIL write_resp: cs=%b tx_valid=%b tx_data=%h want 0 1 4b", mmio_cs, tx_valid, tx_data); end
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL write_done: tx_valid=%b busy=%b want 0 0", tx_valid, busy); end
        @(posedge clk); #1;
        n_tests++;
        if (strobe_cnt - sc0 != 1 || txq.size() != q0 + 1 || txq[q0] !== 8'h4B) begin n_fail++; $display("FAIL write_counts: strobes=%0d bytes=%0d want 1 1 (0x4b)", strobe_cnt - sc0, txq.size() - q0); end
    endtask

    task automatic test_read_stall;
        int sc0, q0;
        logic [7:0] exp_b[4];
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
        sc0 = strobe_cnt;
        q0  = txq.size();
        rd_val = 32'h12345678;
        tx_ready = 1'b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03);
        @(negedge clk);
        n_tests++;
        if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b101 || mmio_addr !== 21'h000103) begin n_fail++; $display("FAIL read_strobe: cs/wr/rd=%b addr=%h want 101 000103", {mmio_cs, mmio_wr, mmio_rd}, mmio_addr); end
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin n_fail++; $display("FAIL read_byte0: valid=%b data=%h want 1 12", tx_valid, tx_data); end
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin n_fail++; $display("FAIL read_stall%0d: valid=%b data=%h want 1 34", i, tx_valid, tx_data); end
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin n_fail++; $display("FAIL read_byte1: valid=%b data=%h want 1 34", tx_valid, tx_data); end
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h56) begin n_fail++; $display("FAIL read_byte2: valid=%b data=%h want 1 56", tx_valid, tx_data); end
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h78) begin n_fail++; $display("FAIL read_byte3: valid=%b data=%h want 1 78", tx_valid, tx_data); end
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL read_done: valid=%b busy=%b want 0 0", tx_valid, busy); end
        @(posedge clk); #1;
        n_tests++;
        if (txq.size() != q0 + 4 || strobe_cnt - sc0 != 1) begin n_fail++; $display("FAIL read_counts: bytes=%0d strobes=%0d want 4 1", txq.size() - q0, strobe_cnt - sc0); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (txq[q0 + i] !== exp_b[i]) begin n_fail++; $display("FAIL read_seq%0d: got %h want %h", i, txq[q0 + i], exp_b[i]); end
        end
    endtask

    task automatic test_addr_mask;
        send_byte(8'h57); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        @(negedge clk);
        n_tests++;
        if (mmio_wr !== 1'b1 || mmio_addr !== 21'h1FFFFF || mmio_wr_data !== 32'h00000001) begin n_fail++; $display("FAIL addr_mask: wr=%b addr=%h data=%h want 1 1fffff 00000001", mmio_wr, mmio_addr, mmio_wr_data); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || mmio_addr !== 21'h1FFFFF) begin n_fail++; $display("FAIL mask_hold: busy=%b addr=%h want 0 1fffff", busy, mmio_addr); end
    endtask

    task automatic test_bad_opcode;
        int sc0, q0, q1;
        logic [7:0] exp_b[4];
        exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        sc0 = strobe_cnt;
        q0  = txq.size();
        @(posedge clk); #1;
        tx_ready = 1'b0;
        send_byte(8'h41);
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3F || mmio_cs !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bad_resp: valid=%b data=%h cs=%b busy=%b want 1 3f 0 1", tx_valid, tx_data, mmio_cs, busy); end
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03);
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin n_fail++; $display("FAIL bad_hold: valid=%b data=%h want 1 3f", tx_valid, tx_data); end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_done: valid=%b busy=%b want 0 0", tx_valid, busy); end
        @(posedge clk); #1;
        n_tests++;
        if (strobe_cnt != sc0 || txq.size() != q0 + 1 || txq[q0] !== 8'h3F) begin n_fail++; $display("FAIL bad_counts: strobes=%0d bytes=%0d want 0 1 (0x3f)", strobe_cnt - sc0, txq.size() - q0); end
        q1 = txq.size();
        rd_val = 32'hCAFEF00D;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        @(negedge clk);
        n_tests++;
        if (mmio_rd !== 1'b1 || mmio_addr !== 21'h000020) begin n_fail++; $display("FAIL after_bad_strobe: rd=%b addr=%h want 1 000020", mmio_rd, mmio_addr); end
        repeat (6) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || txq.size() != q1 + 4) begin n_fail++; $display("FAIL after_bad_done: busy=%b bytes=%0d want 0 4", busy, txq.size() - q1); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (txq[q1 + i] !== exp_b[i]) begin n_fail++; $display("FAIL after_bad_seq%0d: got %h want %h", i, txq[q1 + i], exp_b[i]); end
        end
    endtask

    task automatic test_timeout;
        int sc0, q0;
        sc0 = strobe_cnt;
        q0  = txq.size();
        send_byte(8'h52); send_byte(8'h00);
        repeat (15) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: busy=%b after 15 idle cycles want 1", busy); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || strobe_cnt != sc0 || txq.size() != q0) begin n_fail++; $display("FAIL timeout_abort: busy=%b strobes=%0d bytes=%0d want 0 0 0", busy, strobe_cnt - sc0, txq.size() - q0); end
        rd_val = 32'h0BADCAFE;
        send_byte(8'h52); send_byte(8'h00);
        repeat (14) @(posedge clk);
        send_byte(8'h01); send_byte(8'h03);
        @(negedge clk);
        n_tests++;
        if (mmio_rd !== 1'b1 || mmio_addr !== 21'h000103) begin n_fail++; $display("FAIL timeout_boundary: rd=%b addr=%h want 1 000103", mmio_rd, mmio_addr); end
        repeat (6) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || txq.size() != q0 + 4 || txq[q0] !== 8'h0B || txq[q0 + 3] !== 8'hFE) begin n_fail++; $display("FAIL timeout_boundary_resp: busy=%b bytes=%0d want 0 4 (0b..fe)", busy, txq.size() - q0); end
    endtask

    task automatic test_reset_mid_resp;
        int sc0, q0;
        rd_val = 32'h11223344;
        tx_ready = 1'b1;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01); send_byte(8'h03);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin n_fail++; $display("FAIL rst_pre: valid=%b data=%h want 1 22", tx_valid, tx_data); end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({tx_valid, tx_data, mmio_cs, mmio_wr, mmio_rd, busy} !== 12'h000 || mmio_addr !== 21'h0 || mmio_wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b data=%h cs=%b wr=%b rd=%b busy=%b addr=%h wdata=%h want all 0", tx_valid, tx_data, mmio_cs, mmio_wr, mmio_rd, busy, mmio_addr, mmio_wr_data);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        reset = 1'b0;
        sc0 = strobe_cnt;
        q0  = txq.size();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h44);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        @(negedge clk);
        n_tests++;
        if (mmio_wr !== 1'b1 || mmio_addr !== 21'h000044 || mmio_wr_data !== 32'h01020304) begin n_fail++; $display("FAIL rst_after_write: wr=%b addr=%h data=%h want 1 000044 01020304", mmio_wr, mmio_addr, mmio_wr_data); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        n_tests++;
        if (strobe_cnt - sc0 != 1 || txq.size() != q0 + 1 || txq[q0] !== 8'h4B || busy !== 1'b0) begin n_fail++; $display("FAIL rst_after_counts: strobes=%0d bytes=%0d busy=%b want 1 1 0", strobe_cnt - sc0, txq.size() - q0, busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_addr_mask();
        test_bad_opcode();
        test_timeout();
        test_reset_mid_resp();
        n_tests++;
        if (both_err != 0) begin n_fail++; $display("FAIL strobe_exclusive: wr&rd together %0d times want 0", both_err); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
